load_store_unit: RTL and testbench

Sequencer between the execute stage and the byte-addressed data memory. Accepts one load/store request per handshake, checks alignment and width, drives the memory's address/wdata/width/write_en, captures the memory's combinational read data, sign- or zero-extends it per RISC-V funct3, and returns a response with a fault code. It is the only master of the data memory port.

---
 rtl/rv_pkg.sv | 49 ++++
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 100 ++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V definitions: data width, funct3 codes, LSU state and fault
// encodings, plus the request precheck used when a request is accepted.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE,
        FAULT_MISALIGN,
        FAULT_ACCESS,
        FAULT_ILLEGAL
    } lsu_fault_t;

    // Illegal encoding beats misalignment.
    function automatic lsu_fault_t precheck(
        input logic       store,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic illegal;
        logic misalign;
        if (store)
            illegal = (funct3 >= 3'd3);
        else
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) ||
                      (funct3 == 3'd7);
        misalign = ((funct3[1:0] == 2'd1) && addr_lo[0]) ||
                   ((funct3[1:0] == 2'd2) && (addr_lo != 2'd0));
        if (illegal)
            return FAULT_ILLEGAL;
        else if (misalign)
            return FAULT_MISALIGN;
        else
            return FAULT_NONE;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port of the load/store unit.
// slave: the LSU side; master: execute stage plus memory side.
interface load_store_unit_if;
    import rv_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_fault;

    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [2:0]      mem_width;
    logic            mem_write_en;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_fault;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata, mem_fault,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_addr, mem_wdata, mem_width, mem_write_en
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata, mem_fault,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_addr, mem_wdata, mem_width, mem_write_en
    );

endinterface

// File: rtl/load_extend.sv
// Combinational load-data extension selected by funct3.
// Ports: funct3 in, raw memory word in, extended data out.
module load_extend
    import rv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = raw;
        unique case (funct3)
            F3_B:    data = {{(XLEN-8){raw[7]}}, raw[7:0]};
            F3_H:    data = {{(XLEN-16){raw[15]}}, raw[15:0]};
            F3_BU:   data = {{(XLEN-8){1'b0}}, raw[7:0]};
            F3_HU:   data = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: IDLE -> ACCESS -> RESP, sole master of data memory.
// Ports: clock, reset_n (async low), bus (request/response + memory port).
module load_store_unit
    import rv_pkg::*;
#(
    parameter int MEM_SIZE = 1024
) (
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);

    lsu_state_t      state;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    lsu_fault_t      pre_q;
    lsu_fault_t      fault_q;
    logic [XLEN-1:0] rdata_q;

    logic            access;
    logic            live;
    logic [XLEN:0]   span;
    logic            in_range;
    logic            acc_fault;
    logic [XLEN-1:0] ext;

    assign access = (state == LSU_ACCESS);
    assign live   = access && (pre_q == FAULT_NONE);

    // Extra bit keeps the end-of-access address from wrapping.
    assign span = {1'b0, addr_q}
                + (XLEN+1)'(4'd1 << funct3_q[1:0]);
    assign in_range  = (span <= (XLEN+1)'(MEM_SIZE));
    assign acc_fault = !in_range || bus.mem_fault;

    assign bus.mem_addr     = access ? addr_q : '0;
    assign bus.mem_wdata    = access ? wdata_q : '0;
    assign bus.mem_width    = access ? {1'b0, funct3_q[1:0]} : 3'd0;
    assign bus.mem_write_en = live && store_q && in_range;

    assign bus.req_ready  = (state == LSU_IDLE);
    assign bus.resp_valid = (state == LSU_RESP);
    assign bus.resp_rdata = bus.resp_valid ? rdata_q : '0;
    assign bus.resp_fault = bus.resp_valid ? fault_q : FAULT_NONE;

    load_extend u_ext (
        .funct3 (funct3_q),
        .raw    (bus.mem_rdata),
        .data   (ext)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LSU_IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            pre_q    <= FAULT_NONE;
            fault_q  <= FAULT_NONE;
            rdata_q  <= '0;
        end else begin
            unique case (state)
                LSU_IDLE: begin
                    if (bus.req_valid) begin
                        store_q  <= bus.req_store;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        pre_q    <= precheck(bus.req_store,
                                             bus.req_funct3,
                                             bus.req_addr[1:0]);
                        state    <= LSU_ACCESS;
                    end
                end
                LSU_ACCESS: begin
                    if (pre_q != FAULT_NONE) begin
                        fault_q <= pre_q;
                        rdata_q <= '0;
                    end else if (acc_fault) begin
                        fault_q <= FAULT_ACCESS;
                        rdata_q <= '0;
                    end else begin
                        fault_q <= FAULT_NONE;
                        rdata_q <= store_q ? '0 : ext;
                    end
                    state <= LSU_RESP;
                end
                LSU_RESP: begin
                    if (bus.resp_ready)
                        state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory model
// and a scoreboard of expected responses.
module tb_load_store_unit;
    import rv_pkg::*;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;
    int   wr_cnt;

    logic [7:0] mem [0:1023];

    load_store_unit_if bus ();

    load_store_unit #(.MEM_SIZE(1024)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        bus.mem_rdata = '0;
        for (int k = 0; k < 4; k++)
            if (bus.mem_addr + 32'(k) < 32'd1024)
                bus.mem_rdata[8*k +: 8] = mem[10'(bus.mem_addr + 32'(k))];
        bus.mem_fault = (bus.mem_addr >= 32'd1024);
    end

    always @(posedge clock) begin
        if (bus.mem_write_en) begin
            wr_cnt <= wr_cnt + 1;
            for (int k = 0; k < (1 << bus.mem_width[1:0]); k++)
                mem[10'(bus.mem_addr + 32'(k))] <= bus.mem_wdata[8*k +: 8];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string       name;
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_fault;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
    endtask

    task automatic pop_check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: got empty want entry", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_rdata"}, bus.resp_rdata, e.rdata);
            chk({nm, "_fault"}, 32'(bus.resp_fault), 32'(e.fault));
        end
    endtask

    // Called #1 after a clock edge with the unit idle.
    task automatic run_req(input vec_t v);
        int   n;
        int   w0;
        exp_t e;
        w0 = wr_cnt;
        chk({v.name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        drive(v.store, v.f3, v.addr, v.wdata);
        e.rdata = v.exp_rdata;
        e.fault = v.exp_fault;
        sb.push_back(e);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        chk({v.name, "_acc_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({v.name, "_acc_we"}, 32'(bus.mem_write_en),
            32'(v.store && v.exp_fault == 2'd0));
        n = 0;
        while (!bus.resp_valid && n < 8) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({v.name, "_latency"}, 32'(n), 32'd1);
        if (bus.resp_valid)
            pop_check(v.name);
        else
            void'(sb.pop_front());
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b0;
        chk({v.name, "_writes"}, 32'(wr_cnt - w0),
            32'(v.store && v.exp_fault == 2'd0));
        chk({v.name, "_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        vec_t v;
        int   n;
        errors = 0;
        checks = 0;
        wr_cnt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        vt.push_back('{"sw10",   1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h0,        2'd0});
        vt.push_back('{"lw10",   0, 3'd2, 32'h010, 32'h0,        32'hDEADBEEF, 2'd0});
        vt.push_back('{"sb20",   1, 3'd0, 32'h020, 32'h00000080, 32'h0,        2'd0});
        vt.push_back('{"lb20",   0, 3'd0, 32'h020, 32'h0,        32'hFFFFFF80, 2'd0});
        vt.push_back('{"lbu20",  0, 3'd4, 32'h020, 32'h0,        32'h00000080, 2'd0});
        vt.push_back('{"lh21",   0, 3'd1, 32'h021, 32'h0,        32'h0,        2'd1});
        vt.push_back('{"sw22",   1, 3'd2, 32'h022, 32'h11223344, 32'h0,        2'd1});
        vt.push_back('{"lw20",   0, 3'd2, 32'h020, 32'h0,        32'h00000080, 2'd0});
        vt.push_back('{"lw400",  0, 3'd2, 32'h400, 32'h0,        32'h0,        2'd2});
        vt.push_back('{"sw3fe",  1, 3'd2, 32'h3FE, 32'h55555555, 32'h0,        2'd1});
        vt.push_back('{"sh3fe",  1, 3'd1, 32'h3FE, 32'h1234ABCD, 32'h0,        2'd0});
        vt.push_back('{"lhu3fe", 0, 3'd5, 32'h3FE, 32'h0,        32'h0000ABCD, 2'd0});
        vt.push_back('{"lh3fe",  0, 3'd1, 32'h3FE, 32'h0,        32'hFFFFABCD, 2'd0});
        vt.push_back('{"lw3fc",  0, 3'd2, 32'h3FC, 32'h0,        32'hABCD0000, 2'd0});
        vt.push_back('{"lw3fd",  0, 3'd2, 32'h3FD, 32'h0,        32'h0,        2'd1});
        vt.push_back('{"sb401",  1, 3'd0, 32'h401, 32'h000000AA, 32'h0,        2'd2});
        vt.push_back('{"ld_f3_3",0, 3'd3, 32'h000, 32'h0,        32'h0,        2'd3});
        vt.push_back('{"st_f3_3",1, 3'd3, 32'h000, 32'h0,        32'h0,        2'd3});
        vt.push_back('{"ld_f3_7",0, 3'd7, 32'h001, 32'h0,        32'h0,        2'd3});
        vt.push_back('{"lb3ff",  0, 3'd0, 32'h3FF, 32'h0,        32'hFFFFFFAB, 2'd0});
        vt.push_back('{"sw30",   1, 3'd2, 32'h030, 32'hCAFEF00D, 32'h0,        2'd0});

        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_write_en), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        foreach (vt[i]) run_req(vt[i]);

        // Held response under back-pressure.
        drive(1'b0, 3'd3, 32'h0, 32'h0);
        e.rdata = 32'h0;
        e.fault = 2'd3;
        sb.push_back(e);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clock);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_fault", 32'(bus.resp_fault), 32'd3);
            chk("hold_rdata", bus.resp_rdata, 32'd0);
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        pop_check("hold");
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b0;

        // Reset arriving while a store is in ACCESS.
        n = wr_cnt;
        drive(1'b1, 3'd2, 32'h030, 32'h12345678);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        chk("rst_acc_we_before", 32'(bus.mem_write_en), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_acc_we", 32'(bus.mem_write_en), 32'd0);
        chk("rst_acc_addr", bus.mem_addr, 32'd0);
        chk("rst_acc_wdata", bus.mem_wdata, 32'd0);
        chk("rst_acc_width", 32'(bus.mem_width), 32'd0);
        chk("rst_acc_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_acc_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_acc_rdata", bus.resp_rdata, 32'd0);
        chk("rst_acc_fault", 32'(bus.resp_fault), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_acc_nowrite", 32'(wr_cnt - n), 32'd0);
        v = '{"lw30", 0, 3'd2, 32'h030, 32'h0, 32'hCAFEF00D, 2'd0};
        run_req(v);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
